// File: rtl/vedic_mult_if.sv
// Valid/ready streaming bundle for the Vedic multiplier: operand side and product side.
interface vedic_mult_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, p
   );
endinterface

// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: 2x2 Vedic cells merged level by level with
// carry-lookahead adders, sign-magnitude wrapper, valid/ready streaming with global stall.
module vedic_mult_pipe #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned PIPE_STAGES = 3,
   parameter bit          SIGNED_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   vedic_mult_if.slave bus
);
   localparam int unsigned LV = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   if ((WIDTH < 4) || ((1 << LV) != WIDTH) || (PIPE_STAGES < 1) || (PIPE_STAGES > LV + 1)) begin : g_bad_param
      $error("vedic_mult_pipe: unsupported WIDTH/PIPE_STAGES combination");
   end

   // Level k holds every (a-chunk, b-chunk) product of 2^k-bit chunks; level 0 holds the magnitudes.
   function automatic int unsigned lvl_w(input int unsigned k);
      return (k == 0) ? PW : ((PW * WIDTH) >> k);
   endfunction

   function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic c1;
      c1 = x[1] & y[0] & x[0] & y[1];
      return {x[1] & y[1] & c1, (x[1] & y[1]) ^ c1, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
   endfunction

   // Kogge-Stone prefix carries: g/p collapse over doubling spans, carry into bit i is g[i-1].
   function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, input logic [PW-1:0] y);
      logic [PW-1:0] g;
      logic [PW-1:0] pr;
      g  = x & y;
      pr = x ^ y;
      for (int unsigned d = 1; d < PW; d = d * 2) begin
         g  = g | (pr & (g << d));
         pr = pr & (pr << d);
      end
      return (x ^ y) ^ (g << 1);
   endfunction

   logic w_stall;
   logic w_en;
   logic w_accept;

   assign w_stall      = bus.out_valid && !bus.out_ready;
   assign w_en         = !w_stall;
   assign bus.in_ready = w_en;
   assign w_accept     = bus.in_valid && w_en;

   for (genvar k = 0; k < LV + 1; k++) begin : g_lv
      localparam int unsigned DW = lvl_w(k);
      localparam int unsigned N  = 1 << k;
      localparam int unsigned M  = WIDTH >> k;

      logic [DW-1:0] w_d;
      logic          w_vi;
      logic          w_si;

      if (k == 0) begin : g_abs
         logic w_na;
         logic w_nb;
         assign w_na = SIGNED_EN && bus.signed_mode && bus.a[WIDTH-1];
         assign w_nb = SIGNED_EN && bus.signed_mode && bus.b[WIDTH-1];
         // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
         assign w_d  = {(w_nb ? WIDTH'(-bus.b) : bus.b), (w_na ? WIDTH'(-bus.a) : bus.a)};
         assign w_vi = w_accept;
         assign w_si = w_na ^ w_nb;
      end else if (k == 1) begin : g_cell
         assign w_vi = g_lv[k-1].g_bnd.w_vq;
         assign w_si = g_lv[k-1].g_bnd.w_sq;
         always_comb begin
            w_d = '0;
            for (int unsigned i = 0; i < M; i++) begin
               for (int unsigned j = 0; j < M; j++) begin
                  w_d[(i*M + j)*4 +: 4] = vedic2x2(g_lv[k-1].g_bnd.w_q[2*i +: 2],
                                                   g_lv[k-1].g_bnd.w_q[WIDTH + 2*j +: 2]);
               end
            end
         end
      end else begin : g_merge
         localparam int unsigned H  = N / 2;
         localparam int unsigned MP = 2 * M;
         localparam int unsigned PN = 2 * N;
         assign w_vi = g_lv[k-1].g_bnd.w_vq;
         assign w_si = g_lv[k-1].g_bnd.w_sq;
         // Vertical products (ll, hh) plus the crosswise pair (lh + hl) shifted by half a chunk.
         always_comb begin
            logic [PW-1:0] w_ll;
            logic [PW-1:0] w_lh;
            logic [PW-1:0] w_hl;
            logic [PW-1:0] w_hh;
            logic [PW-1:0] w_cross;
            logic [PW-1:0] w_sum;
            w_d = '0;
            for (int unsigned i = 0; i < M; i++) begin
               for (int unsigned j = 0; j < M; j++) begin
                  w_ll    = PW'(g_lv[k-1].g_bnd.w_q[((2*i)*MP + 2*j)*N +: N]);
                  w_lh    = PW'(g_lv[k-1].g_bnd.w_q[((2*i)*MP + 2*j + 1)*N +: N]);
                  w_hl    = PW'(g_lv[k-1].g_bnd.w_q[((2*i + 1)*MP + 2*j)*N +: N]);
                  w_hh    = PW'(g_lv[k-1].g_bnd.w_q[((2*i + 1)*MP + 2*j + 1)*N +: N]);
                  w_cross = cla_add(w_lh, w_hl);
                  w_sum   = cla_add(cla_add(w_ll, w_cross << H), w_hh << N);
                  w_d[(i*M + j)*PN +: PN] = PN'(w_sum);
               end
            end
            if ((k == LV) && w_si) begin
               w_d = DW'(-w_d);
            end
         end
      end

      // Inter-level boundary: registered for the first PIPE_STAGES-1 levels, wired through otherwise.
      if (k < LV) begin : g_bnd
         logic [DW-1:0] w_q;
         logic          w_vq;
         logic          w_sq;
         if (k + 1 < PIPE_STAGES) begin : g_reg
            logic [DW-1:0] r_d;
            logic          r_v;
            logic          r_s;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_d <= '0;
                  r_v <= 1'b0;
                  r_s <= 1'b0;
               end else if (w_en) begin
                  r_v <= w_vi;
                  if (w_vi) begin
                     r_d <= w_d;
                     r_s <= w_si;
                  end
               end
            end
            assign w_q  = r_d;
            assign w_vq = r_v;
            assign w_sq = r_s;
         end else begin : g_thru
            assign w_q  = w_d;
            assign w_vq = w_vi;
            assign w_sq = w_si;
         end
      end
   end

   logic [PW-1:0] r_p;
   logic          r_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_en) begin
         r_out_valid <= g_lv[LV].w_vi;
         if (g_lv[LV].w_vi) begin
            r_p <= g_lv[LV].w_d;
         end
      end
   end

   assign bus.p         = r_p;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Bench for vedic_mult_pipe: three instances (WIDTH 4/8/16) driven from one process,
// table vectors plus stall/reset sequences and a random stream against a '*' model.
module tb_vedic_mult_pipe;
   localparam int unsigned NDUT = 3;

   function automatic int unsigned dut_w(input int unsigned g);
      return (g == 0) ? 4 : ((g == 1) ? 8 : 16);
   endfunction

   function automatic int unsigned dut_p(input int unsigned g);
      return (g == 0) ? 2 : ((g == 1) ? 3 : 5);
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        tb_iv   [NDUT];
   logic [15:0] tb_a    [NDUT];
   logic [15:0] tb_b    [NDUT];
   logic        tb_sm   [NDUT];
   logic        tb_ordy [NDUT];
   logic        tb_ir   [NDUT];
   logic        tb_ov   [NDUT];
   logic [31:0] tb_p    [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int unsigned W = dut_w(g);
      vedic_mult_if #(.WIDTH(W)) bus ();
      assign bus.in_valid    = tb_iv[g];
      assign bus.a           = W'(tb_a[g]);
      assign bus.b           = W'(tb_b[g]);
      assign bus.signed_mode = tb_sm[g];
      assign bus.out_ready   = tb_ordy[g];
      assign tb_ir[g]        = bus.in_ready;
      assign tb_ov[g]        = bus.out_valid;
      assign tb_p[g]         = 32'(bus.p);
      vedic_mult_pipe #(.WIDTH(W), .PIPE_STAGES(dut_p(g)), .SIGNED_EN(1'b1)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   typedef struct {
      int unsigned sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] e;
      int unsigned c;
   } sb_t;

   sb_t         sbq     [NDUT][$];
   logic [31:0] exp_drv [NDUT];
   bit          acc     [NDUT];
   bit          prev_st [NDUT];
   logic [31:0] prev_p  [NDUT];
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          lat_chk = 1'b0;

   function automatic logic [31:0] model(input int unsigned w, input logic [15:0] a,
                                         input logic [15:0] b, input logic sm);
      longint m, sa, sb;
      m  = (longint'(1) << w) - 1;
      sa = longint'(a) & m;
      sb = longint'(b) & m;
      if (sm && sa[w-1]) sa = sa - (longint'(1) << w);
      if (sm && sb[w-1]) sb = sb - (longint'(1) << w);
      return 32'((sa * sb) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   function automatic logic [15:0] pick(input int unsigned w);
      logic [15:0] m;
      m = 16'((32'd1 << w) - 1);
      case ($urandom_range(0, 7))
         0:       return 16'd0;
         1:       return m;
         2:       return 16'(32'd1 << (w - 1));
         3:       return 16'd1;
         default: return 16'($urandom) & m;
      endcase
   endfunction

   task automatic check(input string nm, input int unsigned g, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s dut%0d (W=%0d) cyc %0d: got 0x%0h, expected 0x%0h", nm, g, dut_w(g), cyc, act, req);
      end
   endtask

   // Scoreboard push on accept, pop on output transfer; stall hold and in_ready rules each cycle.
   task automatic monitor();
      for (int unsigned g = 0; g < NDUT; g++) begin
         sb_t it;
         bit  st;
         st = tb_ov[g] && !tb_ordy[g];
         if (prev_st[g]) begin
            check("stall_hold_p", g, tb_p[g], prev_p[g]);
            check("stall_hold_valid", g, 32'(tb_ov[g]), 32'd1);
         end
         check("in_ready", g, 32'(tb_ir[g]), 32'(!st));
         if (tb_iv[g] && tb_ir[g]) begin
            sbq[g].push_back('{e: exp_drv[g], c: cyc});
            acc[g] = 1'b1;
         end
         if (tb_ov[g] && tb_ordy[g]) begin
            if (sbq[g].size() == 0) begin
               check("spurious_out", g, 32'(tb_ov[g]), 32'd0);
            end else begin
               it = sbq[g].pop_front();
               check("product", g, tb_p[g], it.e);
               if (lat_chk) check("latency", g, cyc - it.c, dut_p(g));
            end
         end
         prev_st[g] = st;
         prev_p[g]  = tb_p[g];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input int unsigned g, input logic [15:0] a, input logic [15:0] b,
                       input logic sm, input logic [31:0] e);
      tb_iv[g]   = 1'b1;
      tb_a[g]    = a;
      tb_b[g]    = b;
      tb_sm[g]   = sm;
      exp_drv[g] = e;
      acc[g]     = 1'b0;
      for (int t = 0; t < 64 && !acc[g]; t++) tick();
      if (!acc[g]) check("send_timeout", g, 32'd0, 32'd1);
      tb_iv[g] = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      for (int unsigned g = 0; g < NDUT; g++) begin
         tb_iv[g]   = 1'b0;
         tb_ordy[g] = 1'b1;
      end
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 100) begin
         tick();
         t++;
      end
      repeat (6) tick();
      for (int unsigned g = 0; g < NDUT; g++) check("drain_empty", g, 32'(sbq[g].size()), 32'd0);
   endtask

   vec_t vt[$];

   initial begin
      int k;
      vt.push_back('{0, 16'd3,    16'd5,    1'b0, 32'd15});
      vt.push_back('{0, 16'd10,   16'd12,   1'b0, 32'd120});
      vt.push_back('{0, 16'd7,    16'd3,    1'b0, 32'd21});
      vt.push_back('{0, 16'd15,   16'd15,   1'b0, 32'd225});
      vt.push_back('{1, 16'd255,  16'd255,  1'b0, 32'h0000_FE01});
      vt.push_back('{1, 16'd0,    16'd200,  1'b0, 32'h0000_0000});
      vt.push_back('{1, 16'd1,    16'd173,  1'b0, 32'd173});
      vt.push_back('{1, 16'hFF,   16'hFF,   1'b1, 32'h0000_0001});
      vt.push_back('{1, 16'h80,   16'h7F,   1'b1, 32'h0000_C080});
      vt.push_back('{1, 16'h80,   16'h80,   1'b1, 32'h0000_4000});
      vt.push_back('{1, 16'h05,   16'hFD,   1'b1, 32'h0000_FFF1});
      vt.push_back('{2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001});
      vt.push_back('{2, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000});
      vt.push_back('{2, 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000});

      for (int unsigned g = 0; g < NDUT; g++) begin
         tb_iv[g] = 1'b0; tb_a[g] = '0; tb_b[g] = '0; tb_sm[g] = 1'b0; tb_ordy[g] = 1'b1;
         exp_drv[g] = '0; acc[g] = 1'b0; prev_st[g] = 1'b0; prev_p[g] = '0;
      end

      repeat (2) @(posedge clk);
      #1;
      for (int unsigned g = 0; g < NDUT; g++) begin
         check("reset_out_valid", g, 32'(tb_ov[g]), 32'd0);
         check("reset_p", g, tb_p[g], 32'd0);
         check("reset_in_ready", g, 32'(tb_ir[g]), 32'd1);
      end
      rst_n = 1'b1;

      // Table vectors, back-to-back per instance with latency checking.
      lat_chk = 1'b1;
      foreach (vt[i]) send(vt[i].sel, vt[i].a, vt[i].b, vt[i].sm, vt[i].exp);
      drain();
      lat_chk = 1'b0;

      // Six ops into the 8-bit instance with out_ready low for four cycles mid-stream.
      k = 0;
      for (int t = 0; t < 60 && (k < 6 || sbq[1].size() != 0); t++) begin
         tb_ordy[1] = !(t >= 4 && t < 8);
         tb_iv[1]   = (k < 6);
         tb_a[1]    = 16'(37 + 29 * k);
         tb_b[1]    = 16'(250 - 41 * k);
         tb_sm[1]   = k[0];
         exp_drv[1] = model(8, tb_a[1], tb_b[1], tb_sm[1]);
         acc[1]     = 1'b0;
         tick();
         if (acc[1]) k++;
      end
      check("stall_ops_sent", 1, 32'(k), 32'd6);
      check("stall_ops_out", 1, 32'(sbq[1].size()), 32'd0);
      drain();

      // Idle inputs with unknown operands must not create output.
      tb_a[1] = 'x;
      tb_b[1] = 'x;
      repeat (4) tick();
      check("idle_x_valid", 1, 32'(tb_ov[1]), 32'd0);

      // Asynchronous reset with three ops in flight.
      tb_ordy[1] = 1'b1;
      send(1, 16'h11, 16'h22, 1'b0, model(8, 16'h11, 16'h22, 1'b0));
      send(1, 16'h93, 16'h47, 1'b1, model(8, 16'h93, 16'h47, 1'b1));
      send(1, 16'hC5, 16'hE9, 1'b0, model(8, 16'hC5, 16'hE9, 1'b0));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 1, 32'(tb_ov[1]), 32'd0);
      check("async_rst_p", 1, tb_p[1], 32'd0);
      for (int unsigned g = 0; g < NDUT; g++) begin
         sbq[g].delete();
         prev_st[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) tick();
      check("post_rst_idle", 1, 32'(tb_ov[1]), 32'd0);
      send(1, 16'h81, 16'h03, 1'b1, model(8, 16'h81, 16'h03, 1'b1));
      drain();

      // Random stream on all three widths with random valid and backpressure.
      for (int t = 0; t < 10000; t++) begin
         for (int unsigned g = 0; g < NDUT; g++) begin
            tb_iv[g]   = ($urandom_range(0, 3) != 0);
            tb_a[g]    = pick(dut_w(g));
            tb_b[g]    = pick(dut_w(g));
            tb_sm[g]   = 1'($urandom);
            tb_ordy[g] = ($urandom_range(0, 3) != 0);
            exp_drv[g] = model(dut_w(g), tb_a[g], tb_b[g], tb_sm[g]);
         end
         tick();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
